// File: rtl/base_initsm_rng.sv
// Index sequencer: sweeps a (base, len) range of table indices over a
// registered valid/ready port, with optional full sweep after reset.
module base_initsm_rng #(
    parameter int LOG_COUNT     = 1,
    parameter int COUNT         = 2 ** LOG_COUNT,
    parameter bit DOWN          = 1'b1,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_v,
    output logic                 i_r,
    input  logic [LOG_COUNT-1:0] i_base,
    input  logic [LOG_COUNT:0]   i_len,
    output logic                 o_v,
    input  logic                 o_r,
    output logic [LOG_COUNT-1:0] o_d,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = LOG_COUNT + 1;
    localparam logic [LOG_COUNT-1:0] RST_FIRST = DOWN ? LOG_COUNT'(COUNT - 1) : '0;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q;
    logic                 o_v_q, done_q, busy_q, i_r_q;
    logic [LOG_COUNT-1:0] o_d_q, nxt_q;
    logic [CW-1:0]        cnt_q;
    logic [LOG_COUNT-1:0] first_d;

    function automatic logic [LOG_COUNT-1:0] step(input logic [LOG_COUNT-1:0] x);
        return DOWN ? x - LOG_COUNT'(1) : x + LOG_COUNT'(1);
    endfunction

    // Descending sweeps start at the top of the range; len=2**LOG_COUNT wraps to base-1.
    always_comb begin
        first_d = i_base;
        if (DOWN) first_d = i_base + i_len[LOG_COUNT-1:0] - LOG_COUNT'(1);
    end

    // cnt_q counts beats still to be loaded after the one currently on o_d.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT_ON_RESET ? RUN : IDLE;
            o_v_q   <= 1'b0;
            o_d_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= INIT_ON_RESET;
            i_r_q   <= !INIT_ON_RESET;
            cnt_q   <= INIT_ON_RESET ? CW'(COUNT) : '0;
            nxt_q   <= RST_FIRST;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_v && i_r_q) begin
                        if (i_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            o_v_q   <= 1'b1;
                            o_d_q   <= first_d;
                            nxt_q   <= step(first_d);
                            cnt_q   <= i_len - CW'(1);
                            busy_q  <= 1'b1;
                            i_r_q   <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (!o_v_q || o_r) begin
                        if (cnt_q != '0) begin
                            o_v_q <= 1'b1;
                            o_d_q <= nxt_q;
                            nxt_q <= step(nxt_q);
                            cnt_q <= cnt_q - CW'(1);
                        end else begin
                            state_q <= IDLE;
                            o_v_q   <= 1'b0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            i_r_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_v  = o_v_q;
    assign o_d  = o_d_q;
    assign done = done_q;
    assign busy = busy_q;
    assign i_r  = i_r_q;

endmodule

// File: tb/tb_base_initsm_rng.sv
// Bench for base_initsm_rng: DUT A (DOWN=1, auto-sweep) and DUT B (DOWN=0, no auto-sweep)
// checked every cycle against a range-list model plus literal beat lists.
module tb_base_initsm_rng;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic       rstA, ivA, irA, ovA, orA, busyA, doneA;
    logic [2:0] baseA, odA;
    logic [3:0] lenA;
    logic       rstB, ivB, irB, ovB, orB, busyB, doneB;
    logic [2:0] baseB, odB;
    logic [3:0] lenB;

    base_initsm_rng #(.LOG_COUNT(3), .COUNT(8), .DOWN(1'b1), .INIT_ON_RESET(1'b1)) dutA (
        .clk(clk), .reset(rstA), .i_v(ivA), .i_r(irA), .i_base(baseA), .i_len(lenA),
        .o_v(ovA), .o_r(orA), .o_d(odA), .busy(busyA), .done(doneA));

    base_initsm_rng #(.LOG_COUNT(3), .COUNT(8), .DOWN(1'b0), .INIT_ON_RESET(1'b0)) dutB (
        .clk(clk), .reset(rstB), .i_v(ivB), .i_r(irB), .i_base(baseB), .i_len(lenB),
        .o_v(ovB), .o_r(orB), .o_d(odB), .busy(busyB), .done(doneB));

    int total = 0;
    int bad   = 0;

    // Model: the expected index list of the sweep in flight and how far it has been consumed.
    int seq [2][8];
    int n_m [2] = '{0, 0};
    int k_m [2] = '{0, 0};
    bit done_exp [2] = '{1'b0, 1'b0};
    bit jr [2] = '{1'b1, 1'b1};
    int cap [2][16];
    int cap_n [2] = '{0, 0};
    int dones [2] = '{0, 0};
    bit armed = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic load_seq(input int d, input int b, input int l, input bit down);
        n_m[d] = l;
        k_m[d] = 0;
        for (int i = 0; i < l; i++)
            seq[d][i] = down ? ((b + l - 1 - i) & 7) : ((b + i) & 7);
    endtask

    task automatic model_step(input int d, input string nm, input logic rst, input logic iv,
                              input logic [2:0] b, input logic [3:0] l, input logic orr,
                              input logic ov, input logic [2:0] od, input logic ir,
                              input logic bs, input logic dn, input bit down, input bit init);
        bit pend, ov_e;
        pend = (k_m[d] < n_m[d]);
        ov_e = pend && !jr[d];
        if (armed) begin
            chk($sformatf("%s.o_v", nm), int'(ov), int'(ov_e));
            if (ov_e) chk($sformatf("%s.o_d", nm), int'(od), seq[d][k_m[d]]);
            chk($sformatf("%s.busy", nm), int'(bs), int'(pend));
            chk($sformatf("%s.i_r", nm), int'(ir), int'(!pend));
            chk($sformatf("%s.done", nm), int'(dn), int'(done_exp[d]));
            if (dn === 1'b1) dones[d]++;
        end
        if (rst) begin
            if (init) load_seq(d, 0, 8, down);
            else begin n_m[d] = 0; k_m[d] = 0; end
            done_exp[d] = 1'b0;
            jr[d] = 1'b1;
        end else begin
            jr[d] = 1'b0;
            done_exp[d] = 1'b0;
            if (pend) begin
                if (ov_e && orr) begin
                    if (cap_n[d] < 16) begin
                        cap[d][cap_n[d]] = int'(od);
                        cap_n[d]++;
                    end
                    k_m[d]++;
                    if (k_m[d] == n_m[d]) done_exp[d] = 1'b1;
                end
            end else if (iv) begin
                load_seq(d, int'(b), int'(l), down);
                if (l == 4'd0) done_exp[d] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0, "A", rstA, ivA, baseA, lenA, orA, ovA, odA, irA, busyA, doneA, 1'b1, 1'b1);
        model_step(1, "B", rstB, ivB, baseB, lenB, orB, ovB, odB, irB, busyB, doneB, 1'b0, 1'b0);
        armed = 1'b1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_cap(input int d, input string nm, input int n, input int e [8]);
        chk($sformatf("%s.beats", nm), cap_n[d], n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s.beat%0d", nm, i), cap[d][i], e[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int d0, d1;
        rstA = 1; ivA = 0; baseA = 0; lenA = 0; orA = 1;
        rstB = 1; ivB = 0; baseB = 0; lenB = 0; orB = 1;
        cyc(3);
        // reset values
        chk("A.rst.o_v", int'(ovA), 0);
        chk("A.rst.o_d", int'(odA), 0);
        chk("A.rst.busy", int'(busyA), 1);
        chk("A.rst.i_r", int'(irA), 0);
        chk("B.rst.busy", int'(busyB), 0);
        chk("B.rst.i_r", int'(irB), 1);
        chk("B.rst.done", int'(doneB), 0);
        rstA = 0; rstB = 0;
        cap_n[0] = 0; cap_n[1] = 0;

        // auto-sweep, descending, consumer always ready
        cyc(12);
        chk_cap(0, "t1", 8, '{7, 6, 5, 4, 3, 2, 1, 0});
        chk("t1.dones", dones[0], 1);
        chk("t1.busy", int'(busyA), 0);
        chk("t1.i_r", int'(irA), 1);

        // auto-sweep with random backpressure
        d0 = dones[0];
        rstA = 1; cyc(1); rstA = 0; cap_n[0] = 0;
        for (int i = 0; i < 40; i++) begin
            orA = 1'($urandom_range(0, 1));
            cyc(1);
        end
        orA = 1; cyc(3);
        chk_cap(0, "t2", 8, '{7, 6, 5, 4, 3, 2, 1, 0});
        chk("t2.dones", dones[0] - d0, 1);

        // B idle after reset, then wrapping ascending range
        chk("t3.idle_beats", cap_n[1], 0);
        baseB = 6; lenB = 4; ivB = 1; cyc(1); ivB = 0;
        cyc(6);
        chk_cap(1, "t3", 4, '{6, 7, 0, 1, 0, 0, 0, 0});
        chk("t3.dones", dones[1], 1);

        // zero-length request, then full-size descending range from base 3
        d1 = dones[1];
        lenB = 0; ivB = 1; cyc(1); ivB = 0;
        chk("t4.len0.done", int'(doneB), 1);
        cyc(2);
        chk("t4.len0.dones", dones[1] - d1, 1);
        chk("t4.len0.beats", cap_n[1], 4);
        cap_n[0] = 0;
        baseA = 3; lenA = 8; ivA = 1; cyc(1); ivA = 0;
        cyc(10);
        chk_cap(0, "t4", 8, '{2, 1, 0, 7, 6, 5, 4, 3});

        // reset mid-sweep aborts without done, auto-sweep restarts
        d0 = dones[0];
        rstA = 1; cyc(1); rstA = 0; cap_n[0] = 0;
        for (int i = 0; i < 20; i++) begin
            if (cap_n[0] >= 3) break;
            cyc(1);
        end
        chk("t5.three_beats", int'(cap_n[0] >= 3), 1);
        rstA = 1; cyc(1); rstA = 0; cap_n[0] = 0;
        cyc(10);
        chk_cap(0, "t5", 8, '{7, 6, 5, 4, 3, 2, 1, 0});
        chk("t5.dones", dones[0] - d0, 1);

        // i_v held through a sweep: second request taken in the done cycle
        d1 = dones[1];
        cap_n[1] = 0;
        baseB = 0; lenB = 2; ivB = 1;
        for (int i = 0; i < 10; i++) begin
            if (dones[1] - d1 >= 1) break;
            cyc(1);
        end
        chk("t6.first_done", int'(dones[1] - d1 >= 1), 1);
        ivB = 0;
        cyc(6);
        chk_cap(1, "t6", 4, '{0, 1, 0, 1, 0, 0, 0, 0});
        chk("t6.dones", dones[1] - d1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
